alu_result_pipe_out: RTL and testbench

//  FPGA-to-host return path for the ALU host interface. Captures ALU results ({z, flags, op}) on a host

---
 rtl/alu_pipe_pkg.sv | 15 +
 rtl/alu_entry_fifo.sv | 51 +++++
 rtl/alu_result_pipe_out.sv | 71 +++++++
 tb/tb_alu_result_pipe_out.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared tag/underrun constants, entry layout and readout-half type for the ALU pipe-out path
package alu_pipe_pkg;
  localparam logic [7:0]  ENTRY_TAG     = 8'hA5;
  localparam logic [31:0] UNDERRUN_WORD = 32'hDEAD_BEEF;
  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  seq;
    logic [2:0]  op;
    logic [2:0]  flags;
  } alu_entry_t;
  typedef enum logic {WORD0, WORD1} half_t;
  function automatic logic [31:0] entry_word1(alu_entry_t e);
    return {ENTRY_TAG, 10'b0, e.seq, e.op, e.flags};
  endfunction
endpackage

// File: rtl/alu_entry_fifo.sv
// alu_entry_fifo: sync FIFO of captured ALU entries with registered count/full/empty
// Ports: clk/rst_n (async active-low); i_flush clears pointers and count; i_push/i_din write
// at the tail (caller only pushes when !o_full or popping); i_pop advances the head;
// o_dout is the current head; o_count/o_full/o_empty are registered status.
module alu_entry_fifo
  import alu_pipe_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  alu_entry_t               i_din,
  input  logic                     i_pop,
  output alu_entry_t               o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  alu_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   w_count_nxt;
  assign w_count_nxt = o_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
  assign o_dout = r_mem[r_rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
      o_full   <= 1'b0;
      o_empty  <= 1'b1;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_count  <= '0;
      o_full   <= 1'b0;
      o_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      o_count <= w_count_nxt;
      o_full  <= w_count_nxt == (AW+1)'(DEPTH);
      o_empty <= w_count_nxt == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

// File: rtl/alu_result_pipe_out.sv
// alu_result_pipe_out: captures ALU results into a FIFO and serialises each as two 32-bit pipe words
// Ports: okClk/rst_n (async active-low); cap_trig captures z/flags/op; clr_trig flushes everything;
// ep_read consumes one word per cycle, ep_datain is registered (valid the cycle after ep_read);
// count/empty/full report FIFO occupancy; drop_err/underrun_err are sticky error flags.
module alu_result_pipe_out
  import alu_pipe_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 8
) (
  input  logic                   okClk,
  input  logic                   rst_n,
  input  logic                   cap_trig,
  input  logic                   clr_trig,
  input  logic [31:0]            z,
  input  logic [2:0]             flags,
  input  logic [2:0]             op,
  input  logic                   ep_read,
  output logic [31:0]            ep_datain,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   drop_err,
  output logic                   underrun_err
);
  logic [SEQ_W-1:0] r_seq;
  half_t            r_half, w_half_nxt;
  alu_entry_t       w_entry, w_head;
  logic             w_push, w_pop;
  assign w_entry = '{z: z, seq: 8'(r_seq), op: op, flags: flags};
  // The entry leaves the FIFO on its second word; a pop that cycle frees a slot for a full-FIFO capture.
  assign w_pop  = ep_read && r_half == WORD1 && !clr_trig;
  assign w_push = cap_trig && (!full || w_pop) && !clr_trig;
  alu_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (okClk),
    .rst_n   (rst_n),
    .i_flush (clr_trig),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );
  always_comb begin
    w_half_nxt = r_half;
    if (clr_trig) w_half_nxt = WORD0;
    else if (ep_read) w_half_nxt = (r_half == WORD1 || empty) ? WORD0 : WORD1;
  end
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      r_half       <= WORD0;
      r_seq        <= '0;
      ep_datain    <= '0;
      drop_err     <= 1'b0;
      underrun_err <= 1'b0;
    end else if (clr_trig) begin
      r_half       <= WORD0;
      r_seq        <= '0;
      drop_err     <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      r_half <= w_half_nxt;
      if (w_push) r_seq <= r_seq + 1'b1;
      if (cap_trig && !w_push) drop_err <= 1'b1;
      if (ep_read && r_half == WORD0 && empty) underrun_err <= 1'b1;
      if (ep_read) ep_datain <= r_half == WORD1 ? entry_word1(w_head) : empty ? UNDERRUN_WORD : w_head.z;
    end
  end
endmodule

// File: tb/tb_alu_result_pipe_out.sv
// tb_alu_result_pipe_out: scoreboard bench; stimulus queues expected pipe words, a monitor compares them
module tb_alu_result_pipe_out;
  logic        okClk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_trig = 1'b0, clr_trig = 1'b0, ep_read = 1'b0;
  logic [31:0] z = '0;
  logic [2:0]  flags = '0, op = '0;
  logic [31:0] ep_datain;
  logic [4:0]  count;
  logic        empty, full, drop_err, underrun_err;
  logic        rd_d;
  logic [31:0] exp_q[$];
  int          n_cmp = 0, n_bad = 0;

  alu_result_pipe_out #(.DEPTH(16), .SEQ_W(8)) dut (
    .okClk(okClk), .rst_n(rst_n), .cap_trig(cap_trig), .clr_trig(clr_trig),
    .z(z), .flags(flags), .op(op), .ep_read(ep_read), .ep_datain(ep_datain),
    .count(count), .empty(empty), .full(full), .drop_err(drop_err), .underrun_err(underrun_err)
  );

  always #5 okClk = ~okClk;

  always @(posedge okClk or negedge rst_n) begin
    if (!rst_n) rd_d <= 1'b0;
    else rd_d <= ep_read && !clr_trig;
  end

  always @(negedge okClk) begin
    if (rd_d) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected: got %h, no word expected", ep_datain);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        if (ep_datain !== e) begin
          n_bad++;
          $display("FAIL rd_word: got %h, expected %h", ep_datain, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] w1(input logic [7:0] s, input logic [2:0] o, input logic [2:0] f);
    return {8'hA5, 10'b0, s, o, f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cap(input logic [31:0] zz, input logic [2:0] oo, input logic [2:0] ff);
    z = zz; op = oo; flags = ff; cap_trig = 1'b1;
    @(negedge okClk);
    cap_trig = 1'b0;
  endtask

  task automatic rd(input logic [31:0] e);
    exp_q.push_back(e);
    ep_read = 1'b1;
    @(negedge okClk);
    ep_read = 1'b0;
  endtask

  task automatic clr();
    clr_trig = 1'b1;
    @(negedge okClk);
    clr_trig = 1'b0;
    @(negedge okClk);
  endtask

  initial begin
    repeat (2) @(negedge okClk);
    chk("rst_datain", ep_datain, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_sticky", {30'b0, drop_err, underrun_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge okClk);
    // 1: single capture, two words out
    cap(32'h0000_0007, 3'd2, 3'b000);
    rd(32'h0000_0007);
    rd(32'hA500_0010);
    chk("t1_empty", 32'(empty), 32'd1);
    // 2: overfill by one, then drain in order
    clr();
    for (int i = 0; i < 17; i++) cap(32'h1000_0000 + i, 3'(i), ~3'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_drop", 32'(drop_err), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd(32'h1000_0000 + i);
      rd(w1(8'(i), 3'(i), ~3'(i)));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    // 3: underrun
    rd(32'hDEAD_BEEF);
    chk("t3_underrun", 32'(underrun_err), 32'd1);
    clr();
    chk("t3_clr_underrun", 32'(underrun_err), 32'd0);
    chk("t3_clr_drop", 32'(drop_err), 32'd0);
    // 4: full FIFO, capture coincides with popping read
    for (int i = 0; i < 16; i++) cap(32'h2000_0000 + i, 3'd5, 3'd1);
    rd(32'h2000_0000);
    exp_q.push_back(w1(8'd0, 3'd5, 3'd1));
    z = 32'h2000_00FF; op = 3'd3; flags = 3'd6;
    cap_trig = 1'b1; ep_read = 1'b1;
    @(negedge okClk);
    cap_trig = 1'b0; ep_read = 1'b0;
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_drop", 32'(drop_err), 32'd0);
    chk("t4_full", 32'(full), 32'd1);
    for (int i = 1; i < 16; i++) begin
      rd(32'h2000_0000 + i);
      rd(w1(8'(i), 3'd5, 3'd1));
    end
    rd(32'h2000_00FF);
    rd(w1(8'd16, 3'd3, 3'd6));
    chk("t4_empty", 32'(empty), 32'd1);
    // 5: sequence wrap with interleaved drains
    clr();
    for (int i = 0; i < 258; i++) begin
      cap(32'h3000_0000 ^ i, 3'd7, 3'd2);
      rd(32'h3000_0000 ^ i);
      rd(w1(8'(i), 3'd7, 3'd2));
    end
    chk("t5_drop", 32'(drop_err), 32'd0);
    chk("t5_underrun", 32'(underrun_err), 32'd0);
    // 6: reset mid-readout
    clr();
    for (int i = 0; i < 3; i++) cap(32'h4000_0000 + i, 3'd1, 3'd0);
    rd(32'h4000_0000);
    @(negedge okClk);
    rst_n = 1'b0;
    #1;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_datain", ep_datain, 32'h0);
    @(negedge okClk);
    rst_n = 1'b1;
    @(negedge okClk);
    rd(32'hDEAD_BEEF);
    chk("t6_underrun", 32'(underrun_err), 32'd1);
    repeat (2) @(negedge okClk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
